// File: rtl/xilinx_primitive_pkg.sv
// Shared types and helpers for the Xilinx primitive wrappers.
// Holds the SDP BRAM reader state encoding and its read-latency rule.
package xilinx_primitive_pkg;

    localparam int RDADDR_WIDTH = 15;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } reader_state_t;

    function automatic int rd_latency(input int do_reg);
        return 1 + do_reg;
    endfunction

endpackage

// File: rtl/xilinx_sdp_bram_reader_if.sv
// Bundles the command port, the BRAM read port and the output stream of the SDP reader.
// master is the reader's view; slave is the view of the surrounding BRAM, commander and consumer.
interface xilinx_sdp_bram_reader_if #(
    parameter int READ_WIDTH = 36,
    parameter int ADDR_WIDTH = 10,
    parameter int LEN_WIDTH  = 16
);
    import xilinx_primitive_pkg::*;

    logic                    CMD_VALID;
    logic                    CMD_READY;
    logic [ADDR_WIDTH-1:0]   CMD_ADDR;
    logic [LEN_WIDTH-1:0]    CMD_LEN;
    logic [RDADDR_WIDTH-1:0] RDADDR;
    logic                    RDEN;
    logic                    REGCE;
    logic [READ_WIDTH-1:0]   DO;
    logic                    M_VALID;
    logic                    M_READY;
    logic [READ_WIDTH-1:0]   M_DATA;
    logic                    M_LAST;
    logic                    BUSY;

    modport master (
        input  CMD_VALID, CMD_ADDR, CMD_LEN, DO, M_READY,
        output CMD_READY, RDADDR, RDEN, REGCE, M_VALID, M_DATA, M_LAST, BUSY
    );

    modport slave (
        output CMD_VALID, CMD_ADDR, CMD_LEN, DO, M_READY,
        input  CMD_READY, RDADDR, RDEN, REGCE, M_VALID, M_DATA, M_LAST, BUSY
    );

endinterface

// File: rtl/xilinx_sdp_reader_fifo.sv
// Output FIFO for the SDP reader: one registered output stage plus DEPTH-1 storage entries.
// count covers the output stage as well, so the reader's credit logic sees total occupancy.
module xilinx_sdp_reader_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic                       rd_valid,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int CW        = $clog2(DEPTH + 1);
    localparam int RAM_DEPTH = DEPTH - 1;
    localparam int PW        = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;

    logic [WIDTH-1:0] ram [RAM_DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    ram_count;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             take_out;
    logic             ram_pop;
    logic             ram_push;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
        return (ptr == PW'(RAM_DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    // A write goes straight to the output stage when that stage is free and storage is empty.
    always_comb begin
        take_out = !out_valid || rd_en;
        ram_pop  = take_out && (ram_count != '0);
        ram_push = wr_en && !(take_out && (ram_count == '0));
    end

    always_ff @(posedge clk) begin
        if (ram_push) begin
            ram[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            ram_count <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (take_out) begin
                if (ram_pop) begin
                    out_data  <= ram[rd_ptr];
                    out_valid <= 1'b1;
                end else if (wr_en) begin
                    out_data  <= wr_data;
                    out_valid <= 1'b1;
                end else begin
                    out_valid <= 1'b0;
                end
            end
            if (ram_push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (ram_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({ram_push, ram_pop})
                2'b10:   ram_count <= ram_count + 1'b1;
                2'b01:   ram_count <= ram_count - 1'b1;
                default: ram_count <= ram_count;
            endcase
        end
    end

    assign rd_valid = out_valid;
    assign rd_data  = out_data;
    assign count    = ram_count + CW'(out_valid);

endmodule

// File: rtl/xilinx_sdp_bram_reader.sv
// Burst read controller for the simple dual-port BRAM read port, delivering a valid/ready stream.
// Optional STALL_CNT output is enabled by defining XILINX_SDP_READER_STALL_CNT_EN.
module xilinx_sdp_bram_reader
    import xilinx_primitive_pkg::*;
#(
    parameter int READ_WIDTH = 36,
    parameter int ADDR_WIDTH = 10,
    parameter int DO_REG     = 1,
    parameter int LEN_WIDTH  = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic CLK,
    input  logic RST,
    xilinx_sdp_bram_reader_if.master bus
`ifdef XILINX_SDP_READER_STALL_CNT_EN
    ,
    output logic [31:0] STALL_CNT
`endif
);
    localparam int LAT = rd_latency(DO_REG);
    localparam int CW  = $clog2(FIFO_DEPTH + 1);

    if (FIFO_DEPTH < LAT + 2) begin : g_depth_check
        $error("xilinx_sdp_bram_reader: FIFO_DEPTH must be at least read latency + 2");
    end

    reader_state_t         state;
    reader_state_t         state_next;
    logic [ADDR_WIDTH-1:0] addr;
    logic [LEN_WIDTH-1:0]  remain;
    logic [LAT-1:0]        tag_valid;
    logic [LAT-1:0]        tag_last;
    logic [CW-1:0]         fifo_count;
    logic [CW-1:0]         inflight;
    logic                  credit;
    logic                  issue;
    logic                  cmd_ready;
    logic                  cmd_fire;
    logic                  fifo_valid;
    logic                  fifo_last;
    logic [READ_WIDTH-1:0] fifo_data;
    logic                  last_fire;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < LAT; i++) begin
            inflight = inflight + CW'(tag_valid[i]);
        end
    end

    // Every issued read already owns a FIFO slot, so the FIFO can never overflow.
    assign credit    = ({1'b0, fifo_count} + {1'b0, inflight}) < (CW + 1)'(FIFO_DEPTH);
    assign last_fire = fifo_valid && bus.M_READY && fifo_last;
    assign cmd_fire  = bus.CMD_VALID && cmd_ready;

    always_comb begin
        state_next = state;
        cmd_ready  = 1'b0;
        issue      = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = !RST;
                if (bus.CMD_VALID && cmd_ready) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                issue = credit && !RST;
                if (issue && (remain == '0)) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (last_fire) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The tag pipeline mirrors the BRAM read latency so DO is captured exactly when it is valid.
    always_ff @(posedge CLK) begin
        if (RST) begin
            addr      <= '0;
            remain    <= '0;
            tag_valid <= '0;
            tag_last  <= '0;
        end else begin
            if (cmd_fire) begin
                addr   <= bus.CMD_ADDR;
                remain <= bus.CMD_LEN;
            end else if (issue) begin
                addr   <= addr + 1'b1;
                remain <= remain - 1'b1;
            end
            tag_valid[0] <= issue;
            tag_last[0]  <= issue && (remain == '0);
            for (int i = 1; i < LAT; i++) begin
                tag_valid[i] <= tag_valid[i-1];
                tag_last[i]  <= tag_last[i-1];
            end
        end
    end

    xilinx_sdp_reader_fifo #(
        .WIDTH(READ_WIDTH + 1),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk     (CLK),
        .rst     (RST),
        .wr_en   (tag_valid[LAT-1]),
        .wr_data ({tag_last[LAT-1], bus.DO}),
        .rd_en   (bus.M_READY),
        .rd_valid(fifo_valid),
        .rd_data ({fifo_last, fifo_data}),
        .count   (fifo_count)
    );

    assign bus.CMD_READY = cmd_ready;
    assign bus.RDADDR    = RDADDR_WIDTH'(addr);
    assign bus.RDEN      = issue;
    assign bus.REGCE     = (DO_REG != 0);
    assign bus.M_VALID   = fifo_valid;
    assign bus.M_DATA    = fifo_data;
    assign bus.M_LAST    = fifo_last;
    assign bus.BUSY      = (state != IDLE);

`ifdef XILINX_SDP_READER_STALL_CNT_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            STALL_CNT <= '0;
        end else if (fifo_valid && !bus.M_READY && (STALL_CNT != '1)) begin
            STALL_CNT <= STALL_CNT + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_xilinx_sdp_bram_reader.sv
// Bench for xilinx_sdp_bram_reader: a DO_REG=1 and a DO_REG=0 instance share one stimulus stream,
// each checked every cycle against a queue-based model of addresses and beats.
module tb_xilinx_sdp_bram_reader;
    import xilinx_primitive_pkg::*;

    localparam int RW    = 36;
    localparam int AW    = 10;
    localparam int LW    = 16;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [LW-1:0] cmd_len = '0;
    logic          m_ready = 1'b0;
    logic          chk_reset_out = 1'b0;
    logic [1:0]    ready_all;
    logic [1:0]    idle_all;
    int            cyc = 0;
    int            tests = 0;
    int            fails = 0;
`ifdef XILINX_SDP_READER_STALL_CNT_EN
    logic          chk_stall = 1'b0;
`endif

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int dut, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s dut%0d: got 0x%0h expected 0x%0h at cycle %0d", name, dut, act, exp, cyc);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int DR        = (g == 0) ? 1 : 0;
        localparam int EXP_FIRST = (g == 0) ? 4 : 3;

        xilinx_sdp_bram_reader_if #(.READ_WIDTH(RW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) bus ();

        logic [RW-1:0] lat_q = '0;
        logic [RW-1:0] oreg_q = '0;
`ifdef XILINX_SDP_READER_STALL_CNT_EN
        logic [31:0]   stall_cnt;
`endif

        xilinx_sdp_bram_reader #(
            .READ_WIDTH(RW),
            .ADDR_WIDTH(AW),
            .DO_REG    (DR),
            .LEN_WIDTH (LW),
            .FIFO_DEPTH(DEPTH)
        ) dut (
            .CLK(clk),
            .RST(rst),
            .bus(bus)
`ifdef XILINX_SDP_READER_STALL_CNT_EN
            ,
            .STALL_CNT(stall_cnt)
`endif
        );

        assign bus.CMD_VALID = cmd_valid;
        assign bus.CMD_ADDR  = cmd_addr;
        assign bus.CMD_LEN   = cmd_len;
        assign bus.M_READY   = m_ready;
        assign ready_all[g]  = bus.CMD_READY;
        assign idle_all[g]   = bus.CMD_READY && !bus.BUSY;

        // BRAM macro read port: preloaded with data equal to the address.
        always @(posedge clk) begin
            if (bus.RDEN) lat_q <= RW'(bus.RDADDR[AW-1:0]);
            if (bus.REGCE) oreg_q <= lat_q;
        end
        assign bus.DO = (DR != 0) ? oreg_q : lat_q;

        logic [14:0]   exp_addr [$];
        logic [RW:0]   exp_beat [$];
        logic [14:0]   wrap_exp [4] = '{15'h3FE, 15'h3FF, 15'h000, 15'h001};
        logic [RW:0]   beat;
        logic [AW-1:0] start_addr = '0;
        bit            busy_m = 1'b0;
        bit            saw_first = 1'b1;
        bit            stalled = 1'b0;
        int            issued = 0;
        int            accepted = 0;
        int            acc_cyc = 0;
        int            burst_len = 0;
        int            wrap_idx = 0;
        int            a;

        always @(negedge clk) begin
            if (rst) begin
                check("cmd_ready_in_reset", g, 64'(bus.CMD_READY), 64'd0);
                exp_addr.delete();
                exp_beat.delete();
                busy_m    = 1'b0;
                saw_first = 1'b1;
                issued    = 0;
                accepted  = 0;
            end else begin
                check("regce", g, 64'(bus.REGCE), 64'(DR));
                check("cmd_ready", g, 64'(bus.CMD_READY), 64'(!busy_m));
                check("busy", g, 64'(bus.BUSY), 64'(busy_m));
                if (chk_reset_out) begin
                    check("post_reset_rden", g, 64'(bus.RDEN), 64'd0);
                    check("post_reset_rdaddr", g, 64'(bus.RDADDR), 64'd0);
                    check("post_reset_m_valid", g, 64'(bus.M_VALID), 64'd0);
                    check("post_reset_m_last", g, 64'(bus.M_LAST), 64'd0);
                    check("post_reset_m_data", g, 64'(bus.M_DATA), 64'd0);
                    check("post_reset_busy", g, 64'(bus.BUSY), 64'd0);
                    check("post_reset_cmd_ready", g, 64'(bus.CMD_READY), 64'd1);
                end
                if (bus.RDEN) begin
                    if (exp_addr.size() == 0) begin
                        check("rden_unexpected", g, 64'd1, 64'd0);
                    end else begin
                        check("rdaddr", g, 64'(bus.RDADDR), 64'(exp_addr.pop_front()));
                        if (start_addr == 10'h3FE && wrap_idx < 4) begin
                            check("rdaddr_wrap", g, 64'(bus.RDADDR), 64'(wrap_exp[wrap_idx]));
                            wrap_idx++;
                        end
                        issued++;
                    end
                end
                check("outstanding_le_depth", g, 64'(issued - accepted <= DEPTH), 64'd1);
                if (!m_ready && busy_m) stalled = 1'b1;
                if (bus.M_VALID) begin
                    if (!saw_first) begin
                        check("first_valid_latency", g, 64'(cyc - acc_cyc), 64'(EXP_FIRST));
                        saw_first = 1'b1;
                    end
                    if (exp_beat.size() == 0) begin
                        check("m_valid_unexpected", g, 64'd1, 64'd0);
                    end else begin
                        beat = exp_beat[0];
                        check("m_data", g, 64'(bus.M_DATA), 64'(beat[RW-1:0]));
                        check("m_last", g, 64'(bus.M_LAST), 64'(beat[RW]));
                        if (m_ready) begin
                            void'(exp_beat.pop_front());
                            accepted++;
                            if (beat[RW]) begin
                                check("reads_all_issued", g, 64'(exp_addr.size()), 64'd0);
                                if (!stalled) begin
                                    check("burst_no_bubbles", g, 64'(cyc - acc_cyc), 64'(EXP_FIRST + burst_len));
                                end
                                busy_m = 1'b0;
                            end
                        end
                    end
                end
                if (cmd_valid && bus.CMD_READY) begin
                    busy_m     = 1'b1;
                    acc_cyc    = cyc;
                    saw_first  = 1'b0;
                    stalled    = 1'b0;
                    start_addr = cmd_addr;
                    wrap_idx   = 0;
                    burst_len  = int'(cmd_len);
                    for (int i = 0; i <= int'(cmd_len); i++) begin
                        a = (int'(cmd_addr) + i) % (1 << AW);
                        exp_addr.push_back(15'(a));
                        exp_beat.push_back({(i == int'(cmd_len)), RW'(a)});
                    end
                end
            end
        end

`ifdef XILINX_SDP_READER_STALL_CNT_EN
        always @(negedge clk) begin
            if (chk_stall) check("stall_cnt_min", g, 64'(stall_cnt >= 32'd20), 64'd1);
        end
`endif
    end

    task automatic step(input bit rand_ready);
        @(posedge clk);
        #1;
        if (rand_ready) m_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send_cmd(input logic [AW-1:0] addr, input logic [LW-1:0] len, input bit rand_ready);
        int n = 0;
        while (ready_all != 2'b11 && n < 500) begin
            step(rand_ready);
            n++;
        end
        if (n >= 500) check("cmd_ready_timeout", 0, 64'd0, 64'd1);
        cmd_addr  = addr;
        cmd_len   = len;
        cmd_valid = 1'b1;
        step(rand_ready);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input bit rand_ready);
        int n = 0;
        while (idle_all != 2'b11 && n < 2000) begin
            step(rand_ready);
            n++;
        end
        if (n >= 2000) check("idle_timeout", 0, 64'd0, 64'd1);
    endtask

    initial begin
        repeat (3) step(1'b0);
        rst = 1'b0;
        chk_reset_out = 1'b1;
        step(1'b0);
        chk_reset_out = 1'b0;

        m_ready = 1'b1;
        send_cmd(10'h010, 16'd3, 1'b0);
        wait_idle(1'b0);
        send_cmd(10'h010, 16'd0, 1'b0);
        wait_idle(1'b0);
        send_cmd(10'h3FE, 16'd3, 1'b0);
        wait_idle(1'b0);

        // Backpressure: the consumer stalls long enough for issue to run out of credit.
        m_ready = 1'b0;
        send_cmd(10'h020, 16'd15, 1'b0);
        repeat (24) step(1'b0);
        m_ready = 1'b1;
        wait_idle(1'b0);
`ifdef XILINX_SDP_READER_STALL_CNT_EN
        chk_stall = 1'b1;
        step(1'b0);
        chk_stall = 1'b0;
`endif

        for (int b = 0; b < 25; b++) begin
            send_cmd(AW'($urandom_range(0, 1023)), LW'($urandom_range(0, 12)), 1'b1);
            wait_idle(1'b1);
        end

        // Reset pulse in the middle of a burst, then a fresh burst must carry no stale beats.
        m_ready = 1'b1;
        send_cmd(10'h100, 16'd10, 1'b0);
        repeat (5) step(1'b0);
        rst = 1'b1;
        step(1'b0);
        rst = 1'b0;
        chk_reset_out = 1'b1;
        step(1'b0);
        chk_reset_out = 1'b0;
        send_cmd(10'h200, 16'd5, 1'b0);
        wait_idle(1'b0);
        send_cmd(10'h3F0, 16'd20, 1'b1);
        wait_idle(1'b1);
        repeat (3) step(1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
